// File: rtl/rps_pkg.sv
// Shared constants and types for the stone-paper-scissors match scorer:
// judge byte codes, champion encoding, match state and decoded result.
package rps_pkg;

    localparam logic [7:0] RES_TIE = 8'h00;
    localparam logic [7:0] RES_P1  = 8'h31;
    localparam logic [7:0] RES_P2  = 8'h32;
    localparam logic [7:0] RES_INV = 8'h3F;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_P1   = 2'b01;
    localparam logic [1:0] CH_P2   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic tie;
        logic p1;
        logic p2;
        logic inv;
        logic err;
    } res_hot_t;

    // Higher score wins; level scores give no champion.
    function automatic logic [1:0] pick_champion(input logic [3:0] a, input logic [3:0] b);
        if (a > b)      return CH_P1;
        else if (b > a) return CH_P2;
        else            return CH_NONE;
    endfunction

endpackage

// File: rtl/rps_result_decoder.sv
// Combinational decode of one judge result byte into a one-hot class.
module rps_result_decoder
    import rps_pkg::*;
(
    input  logic [7:0] result_byte,
    output res_hot_t   hot
);

    always_comb begin
        hot = '0;
        case (result_byte)
            RES_TIE: hot.tie = 1'b1;
            RES_P1:  hot.p1  = 1'b1;
            RES_P2:  hot.p2  = 1'b1;
            RES_INV: hot.inv = 1'b1;
            default: hot.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rps_match_scorer.sv
// Best-of-N match FSM: counts judge results, saturates tie/invalid tallies,
// and declares a champion on win target or round limit.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] result_byte,
    input  logic       result_valid,
    output logic       playing,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] ties,
    output logic [3:0] invalids,
    output logic [4:0] rounds,
    output logic       match_over,
    output logic [1:0] champion,
    output logic       proto_err
);

    localparam logic [3:0] WIN  = 4'(WIN_TARGET);
    localparam logic [4:0] MAXR = 5'(MAX_ROUNDS);

    state_t     state, state_d;
    res_hot_t   hot;
    logic [3:0] p1_d, p2_d, ties_d, inv_d;
    logic [4:0] rounds_d;
    logic [1:0] champion_d;
    logic       proto_err_d;
    logic [3:0] p1_inc, p2_inc;
    logic [4:0] rounds_inc;

    rps_result_decoder u_decoder (
        .result_byte (result_byte),
        .hot         (hot)
    );

    assign p1_inc     = p1_score + 4'd1;
    assign p2_inc     = p2_score + 4'd1;
    assign rounds_inc = rounds + 5'd1;

    always_comb begin
        state_d     = state;
        p1_d        = p1_score;
        p2_d        = p2_score;
        ties_d      = ties;
        inv_d       = invalids;
        rounds_d    = rounds;
        champion_d  = champion;
        proto_err_d = proto_err;

        if (start) begin
            // A result arriving with start is dropped along with the old match.
            state_d     = PLAY;
            p1_d        = '0;
            p2_d        = '0;
            ties_d      = '0;
            inv_d       = '0;
            rounds_d    = '0;
            champion_d  = CH_NONE;
            proto_err_d = 1'b0;
        end else if (state == PLAY && result_valid) begin
            if (hot.p1) begin
                p1_d     = p1_inc;
                rounds_d = rounds_inc;
                if (p1_inc == WIN) begin
                    state_d    = DONE;
                    champion_d = CH_P1;
                end else if (rounds_inc == MAXR) begin
                    state_d    = DONE;
                    champion_d = pick_champion(p1_inc, p2_score);
                end
            end else if (hot.p2) begin
                p2_d     = p2_inc;
                rounds_d = rounds_inc;
                if (p2_inc == WIN) begin
                    state_d    = DONE;
                    champion_d = CH_P2;
                end else if (rounds_inc == MAXR) begin
                    state_d    = DONE;
                    champion_d = pick_champion(p1_score, p2_inc);
                end
            end else if (hot.tie) begin
                ties_d   = (ties == 4'hF) ? ties : ties + 4'd1;
                rounds_d = rounds_inc;
                if (rounds_inc == MAXR) begin
                    state_d    = DONE;
                    champion_d = pick_champion(p1_score, p2_score);
                end
            end else if (hot.inv) begin
                inv_d = (invalids == 4'hF) ? invalids : invalids + 4'd1;
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    // playing/match_over are registered from the next state so they move with the scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            playing    <= 1'b0;
            match_over <= 1'b0;
            p1_score   <= '0;
            p2_score   <= '0;
            ties       <= '0;
            invalids   <= '0;
            rounds     <= '0;
            champion   <= CH_NONE;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_d;
            playing    <= (state_d == PLAY);
            match_over <= (state_d == DONE);
            p1_score   <= p1_d;
            p2_score   <= p2_d;
            ties       <= ties_d;
            invalids   <= inv_d;
            rounds     <= rounds_d;
            champion   <= champion_d;
            proto_err  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed bench for rps_match_scorer: one default instance and one with a
// four-round limit, checked against hand-computed values.
module tb_rps_match_scorer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_start = 1'b0, a_valid = 1'b0;
    logic [7:0] a_byte = 8'h00;
    logic       a_playing, a_over, a_perr;
    logic [3:0] a_p1, a_p2, a_ties, a_inv;
    logic [4:0] a_rounds;
    logic [1:0] a_champ;

    logic       b_start = 1'b0, b_valid = 1'b0;
    logic [7:0] b_byte = 8'h00;
    logic       b_playing, b_over, b_perr;
    logic [3:0] b_p1, b_p2, b_ties, b_inv;
    logic [4:0] b_rounds;
    logic [1:0] b_champ;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rps_match_scorer #(.WIN_TARGET(3), .MAX_ROUNDS(15)) dut_a (
        .clk (clk), .rst_n (rst_n), .start (a_start),
        .result_byte (a_byte), .result_valid (a_valid),
        .playing (a_playing), .p1_score (a_p1), .p2_score (a_p2),
        .ties (a_ties), .invalids (a_inv), .rounds (a_rounds),
        .match_over (a_over), .champion (a_champ), .proto_err (a_perr)
    );

    rps_match_scorer #(.WIN_TARGET(3), .MAX_ROUNDS(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .start (b_start),
        .result_byte (b_byte), .result_valid (b_valid),
        .playing (b_playing), .p1_score (b_p1), .p2_score (b_p2),
        .ties (b_ties), .invalids (b_inv), .rounds (b_rounds),
        .match_over (b_over), .champion (b_champ), .proto_err (b_perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        a_byte = b; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        b_byte = b; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    task automatic check_clear_a(input string tag);
        check({tag, ".p1"}, 32'(a_p1), 0);
        check({tag, ".p2"}, 32'(a_p2), 0);
        check({tag, ".ties"}, 32'(a_ties), 0);
        check({tag, ".inv"}, 32'(a_inv), 0);
        check({tag, ".rounds"}, 32'(a_rounds), 0);
        check({tag, ".champ"}, 32'(a_champ), 0);
        check({tag, ".perr"}, 32'(a_perr), 0);
    endtask

    initial begin
        #12;
        check_clear_a("rst");
        check("rst.playing", 32'(a_playing), 0);
        check("rst.over", 32'(a_over), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Results in IDLE are ignored.
        send_a(8'h31);
        check("idle.p1", 32'(a_p1), 0);
        check("idle.rounds", 32'(a_rounds), 0);
        check("idle.playing", 32'(a_playing), 0);

        start_a();
        check("start.playing", 32'(a_playing), 1);
        check_clear_a("start");

        // Three P1 wins back to back take the match.
        send_a(8'h31);
        check("w1.p1", 32'(a_p1), 1);
        send_a(8'h31);
        check("w2.p1", 32'(a_p1), 2);
        check("w2.over", 32'(a_over), 0);
        send_a(8'h31);
        check("w3.p1", 32'(a_p1), 3);
        check("w3.rounds", 32'(a_rounds), 3);
        check("w3.over", 32'(a_over), 1);
        check("w3.champ", 32'(a_champ), 1);
        check("w3.playing", 32'(a_playing), 0);

        // Results in DONE are ignored.
        send_a(8'h32);
        check("done.p2", 32'(a_p2), 0);
        check("done.p1", 32'(a_p1), 3);
        check("done.rounds", 32'(a_rounds), 3);

        start_a();
        check("restart.playing", 32'(a_playing), 1);
        check("restart.over", 32'(a_over), 0);
        check_clear_a("restart");

        send_a(8'h00);
        send_a(8'h32);
        send_a(8'h3F);
        send_a(8'h41);
        check("mix.ties", 32'(a_ties), 1);
        check("mix.p2", 32'(a_p2), 1);
        check("mix.inv", 32'(a_inv), 1);
        check("mix.rounds", 32'(a_rounds), 2);
        check("mix.perr", 32'(a_perr), 1);
        check("mix.playing", 32'(a_playing), 1);

        // Invalid count saturates at 15 and does not advance rounds.
        for (int i = 0; i < 16; i++) send_a(8'h3F);
        check("sat.inv", 32'(a_inv), 15);
        check("sat.rounds", 32'(a_rounds), 2);

        // start wins over a simultaneous result.
        a_start = 1'b1; a_valid = 1'b1; a_byte = 8'h32;
        tick();
        a_start = 1'b0; a_valid = 1'b0;
        check_clear_a("startpri");
        check("startpri.playing", 32'(a_playing), 1);

        // Asynchronous reset mid-match.
        send_a(8'h31);
        send_a(8'h31);
        check("pre_rst.p1", 32'(a_p1), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_clear_a("async");
        check("async.playing", 32'(a_playing), 0);
        check("async.over", 32'(a_over), 0);
        #1;
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst.playing", 32'(a_playing), 0);
        check("post_rst.over", 32'(a_over), 0);

        // Four-round limit, level scores.
        start_b();
        send_b(8'h31);
        send_b(8'h32);
        send_b(8'h00);
        check("lim1.over3", 32'(b_over), 0);
        send_b(8'h00);
        check("lim1.over", 32'(b_over), 1);
        check("lim1.champ", 32'(b_champ), 0);
        check("lim1.rounds", 32'(b_rounds), 4);
        check("lim1.ties", 32'(b_ties), 2);

        // Same but P1 takes the last round.
        start_b();
        check("lim2.start", 32'(b_over), 0);
        send_b(8'h31);
        send_b(8'h32);
        send_b(8'h00);
        send_b(8'h31);
        check("lim2.over", 32'(b_over), 1);
        check("lim2.champ", 32'(b_champ), 1);
        check("lim2.p1", 32'(b_p1), 2);

        // Win target reached on the final round.
        start_b();
        send_b(8'h32);
        send_b(8'h32);
        send_b(8'h31);
        send_b(8'h32);
        check("lim3.over", 32'(b_over), 1);
        check("lim3.champ", 32'(b_champ), 2);
        check("lim3.p2", 32'(b_p2), 3);
        check("lim3.playing", 32'(b_playing), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
